clusterv_sram_byte_en_arb: RTL and testbench

Parametrised byte-enable SRAM target shared by two initiator ports through a round-robin arbiter. Successor to the cluster's single-port main SRAM wrapper, adding:
- generic width and depth
- valid/ready request handshake with a registered read response
- out-of-range error reporting
- a hardware clear engine that zeroes the array on reset or on request

Sits between cluster initiators (e.g. core data port and DMA) and local scratch memory.

---
 rtl/clusterv_sram_byte_en_arb_if.sv | 26 ++
 rtl/clusterv_sram_byte_en_arb.sv | 148 ++++++++++++++
 tb/tb_clusterv_sram_byte_en_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clusterv_sram_byte_en_arb_if.sv
// Request/response bundle for one initiator port of the shared byte-enable SRAM.
// The initiator side uses the master modport; the SRAM side uses slave.
interface clusterv_sram_byte_en_arb_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                      req;
  logic                      ready;
  logic                      write_en;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [DATA_WIDTH/8-1:0]   byte_en;
  logic [DATA_WIDTH-1:0]     write_data;
  logic                      rvalid;
  logic [DATA_WIDTH-1:0]     read_data;
  logic                      err;

  modport master (
    output req, write_en, addr, byte_en, write_data,
    input  ready, rvalid, read_data, err
  );

  modport slave (
    input  req, write_en, addr, byte_en, write_data,
    output ready, rvalid, read_data, err
  );
endinterface

// File: rtl/clusterv_sram_byte_en_arb.sv
// Byte-enable SRAM shared by two initiators through a round-robin arbiter, with a
// registered response path, out-of-range reporting and a zeroing clear engine.
module clusterv_sram_byte_en_arb #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH          = 256,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear_req,
  output logic                        clear_busy,
  clusterv_sram_byte_en_arb_if.slave  p0,
  clusterv_sram_byte_en_arb_if.slave  p1
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned OffW     = (NumBytes > 1) ? $clog2(NumBytes) : 0;
  localparam int unsigned IdxW     = ADDR_WIDTH - OffW;
  localparam int unsigned CntW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IdxW:0]   DepthLim = DEPTH[IdxW:0];
  localparam logic [CntW-1:0] LastWord = CntW'(DEPTH - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StClear = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  last_grant_q;

  logic                  grant;
  logic                  accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [NumBytes-1:0]   sel_be;
  logic [DATA_WIDTH-1:0] sel_wd;
  logic [IdxW-1:0]       sel_idx;
  logic [CntW-1:0]       sel_word;
  logic                  oor;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  rvalid0_q, rvalid1_q;
  logic                  err0_q, err1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Ties go to the port that did not win the previous accept.
  always_comb begin
    grant    = (p0.req && p1.req) ? ~last_grant_q : p1.req;
    accept   = (p0.req || p1.req) && (state_q == StIdle) && !clear_req;
    sel_we   = grant ? p1.write_en   : p0.write_en;
    sel_addr = grant ? p1.addr       : p0.addr;
    sel_be   = grant ? p1.byte_en    : p0.byte_en;
    sel_wd   = grant ? p1.write_data : p0.write_data;
    sel_idx  = sel_addr[ADDR_WIDTH-1:OffW];
    sel_word = sel_idx[CntW-1:0];
    oor      = ({1'b0, sel_idx} >= DepthLim);
    rd_word  = oor ? '0 : mem[sel_word];
  end

  generate
    if (OffW > 0) begin : g_unused_lsb
      logic unused_addr_lsb;
      assign unused_addr_lsb = ^sel_addr[OffW-1:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastWord) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= CLEAR_ON_RESET ? StClear : StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= accept && !grant;
      rvalid1_q <= accept && grant;
      err0_q    <= accept && !grant && oor;
      err1_q    <= accept && grant && oor;
      if (accept) begin
        last_grant_q <= grant;
      end
      // Read data is held until the next read on the same port.
      if (accept && !grant && !sel_we) begin
        rdata0_q <= rd_word;
      end
      if (accept && grant && !sel_we) begin
        rdata1_q <= rd_word;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == StClear) begin
      mem[cnt_q] <= '0;
    end else if (accept && sel_we && !oor) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (sel_be[b]) begin
          mem[sel_word][b*8 +: 8] <= sel_wd[b*8 +: 8];
        end
      end
    end
  end

  // Ready is masked while reset is held so a non-clearing build shows no accept.
  assign p0.ready     = accept && !grant && reset;
  assign p1.ready     = accept && grant && reset;
  assign p0.rvalid    = rvalid0_q;
  assign p1.rvalid    = rvalid1_q;
  assign p0.err       = err0_q;
  assign p1.err       = err1_q;
  assign p0.read_data = rdata0_q;
  assign p1.read_data = rdata1_q;
  assign clear_busy   = (state_q == StClear);

endmodule

// File: tb/tb_clusterv_sram_byte_en_arb.sv
// Scenario bench for the shared byte-enable SRAM: directed feature tasks followed by
// randomized two-port traffic checked against a word-array model of the memory.
module tb_clusterv_sram_byte_en_arb;

  logic clock = 1'b0;
  logic reset;
  logic clr_a, clr_b, busy_a, busy_b;

  always #5 clock = ~clock;

  clusterv_sram_byte_en_arb_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) a0 ();
  clusterv_sram_byte_en_arb_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) a1 ();
  clusterv_sram_byte_en_arb_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) b0 ();
  clusterv_sram_byte_en_arb_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) b1 ();

  // Index 0,1 = ports of the 256-word instance; 2,3 = ports of the 200-word instance.
  logic        req_s  [4];
  logic        we_s   [4];
  logic [9:0]  addr_s [4];
  logic [3:0]  be_s   [4];
  logic [31:0] wd_s   [4];
  logic        rdy    [4];
  logic        rv     [4];
  logic        er     [4];
  logic [31:0] rd     [4];

  assign a0.req = req_s[0]; assign a0.write_en = we_s[0]; assign a0.addr = addr_s[0];
  assign a0.byte_en = be_s[0]; assign a0.write_data = wd_s[0];
  assign a1.req = req_s[1]; assign a1.write_en = we_s[1]; assign a1.addr = addr_s[1];
  assign a1.byte_en = be_s[1]; assign a1.write_data = wd_s[1];
  assign b0.req = req_s[2]; assign b0.write_en = we_s[2]; assign b0.addr = addr_s[2];
  assign b0.byte_en = be_s[2]; assign b0.write_data = wd_s[2];
  assign b1.req = req_s[3]; assign b1.write_en = we_s[3]; assign b1.addr = addr_s[3];
  assign b1.byte_en = be_s[3]; assign b1.write_data = wd_s[3];

  assign rdy[0] = a0.ready; assign rv[0] = a0.rvalid; assign er[0] = a0.err;
  assign rd[0] = a0.read_data;
  assign rdy[1] = a1.ready; assign rv[1] = a1.rvalid; assign er[1] = a1.err;
  assign rd[1] = a1.read_data;
  assign rdy[2] = b0.ready; assign rv[2] = b0.rvalid; assign er[2] = b0.err;
  assign rd[2] = b0.read_data;
  assign rdy[3] = b1.ready; assign rv[3] = b1.rvalid; assign er[3] = b1.err;
  assign rd[3] = b1.read_data;

  clusterv_sram_byte_en_arb #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(256), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .clear_req(clr_a), .clear_busy(busy_a),
    .p0(a0), .p1(a1)
  );

  clusterv_sram_byte_en_arb #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(200), .CLEAR_ON_RESET(1'b1)
  ) dut_oor (
    .clock(clock), .reset(reset), .clear_req(clr_b), .clear_busy(busy_b),
    .p0(b0), .p1(b1)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mem_a [256];

  // Drives one request on port p, holds it until ready (bounded), reports the
  // response seen in the following cycle.
  task automatic do_access(input int p, input logic w, input logic [9:0] ad,
                           input logic [3:0] b, input logic [31:0] d, output bit acc,
                           output logic got_rv, output logic [31:0] got_rd,
                           output logic got_er);
    @(posedge clock); #1;
    req_s[p] = 1'b1; we_s[p] = w; addr_s[p] = ad; be_s[p] = b; wd_s[p] = d;
    acc = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (rdy[p] === 1'b1) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clock); #1;
    req_s[p] = 1'b0;
    @(negedge clock);
    got_rv = rv[p]; got_rd = rd[p]; got_er = er[p];
  endtask

  task automatic test_reset();
    int busy_cnt, bad_rdy;
    reset = 1'b1;
    #2 reset = 1'b0;
    req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 10'd68; be_s[0] = 4'h0; wd_s[0] = '0;
    repeat (3) @(negedge clock);
    n_checks++; if (busy_a !== 1'b1) begin n_errors++;
      $display("FAIL reset_busy: got %b expected 1", busy_a); end
    n_checks++; if (rdy[0] !== 1'b0) begin n_errors++;
      $display("FAIL reset_ready: got %b expected 0", rdy[0]); end
    n_checks++; if (rv[0] !== 1'b0 || rv[1] !== 1'b0) begin n_errors++;
      $display("FAIL reset_rvalid: got %b%b expected 00", rv[1], rv[0]); end
    n_checks++; if (er[0] !== 1'b0 || er[1] !== 1'b0) begin n_errors++;
      $display("FAIL reset_err: got %b%b expected 00", er[1], er[0]); end
    n_checks++; if (rd[0] !== 32'h0 || rd[1] !== 32'h0) begin n_errors++;
      $display("FAIL reset_rdata: got %h %h expected 0", rd[0], rd[1]); end
    @(posedge clock); #1 reset = 1'b1;
    busy_cnt = 0; bad_rdy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (busy_a !== 1'b1) break;
      busy_cnt++;
      if (rdy[0] !== 1'b0) bad_rdy++;
    end
    n_checks++; if (busy_cnt != 256) begin n_errors++;
      $display("FAIL post_reset_clear_len: got %0d expected 256", busy_cnt); end
    n_checks++; if (bad_rdy != 0) begin n_errors++;
      $display("FAIL ready_during_clear: got %0d cycles expected 0", bad_rdy); end
    n_checks++; if (rdy[0] !== 1'b1) begin n_errors++;
      $display("FAIL first_accept_after_clear: got %b expected 1", rdy[0]); end
    @(posedge clock); #1 req_s[0] = 1'b0;
    @(negedge clock);
    n_checks++; if (rv[0] !== 1'b1 || rd[0] !== 32'h0 || er[0] !== 1'b0) begin n_errors++;
      $display("FAIL read_word17: got rv=%b d=%h e=%b expected rv=1 d=0 e=0",
               rv[0], rd[0], er[0]); end
    for (int i = 0; i < 256; i++) mem_a[i] = '0;
  endtask

  task automatic test_byte_lanes();
    bit acc; logic grv, ger; logic [31:0] grd;
    do_access(0, 1'b1, 10'h040, 4'b1111, 32'hAABBCCDD, acc, grv, grd, ger);
    n_checks++; if (!acc || grv !== 1'b1 || ger !== 1'b0) begin n_errors++;
      $display("FAIL write_full: got acc=%b rv=%b e=%b expected 1 1 0", acc, grv, ger); end
    do_access(0, 1'b1, 10'h040, 4'b0101, 32'h11223344, acc, grv, grd, ger);
    n_checks++; if (!acc || grv !== 1'b1 || ger !== 1'b0) begin n_errors++;
      $display("FAIL write_partial: got acc=%b rv=%b e=%b expected 1 1 0", acc, grv, ger); end
    // Low address bits must be ignored.
    do_access(0, 1'b0, 10'h042, 4'b0000, 32'h0, acc, grv, grd, ger);
    n_checks++; if (grv !== 1'b1 || grd !== 32'hAA22CC44 || ger !== 1'b0) begin n_errors++;
      $display("FAIL byte_lane_read: got rv=%b d=%h e=%b expected 1 aa22cc44 0",
               grv, grd, ger); end
    mem_a[16] = 32'hAA22CC44;
  endtask

  task automatic test_back_to_back();
    bit acc;
    @(posedge clock); #1;
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 10'd80; be_s[0] = 4'hF;
    wd_s[0] = 32'h5A5AA5A5;
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (rdy[0] === 1'b1) begin acc = 1'b1; break; end
    end
    n_checks++; if (!acc) begin n_errors++;
      $display("FAIL b2b_write_accept: got 0 expected 1"); end
    @(posedge clock); #1 we_s[0] = 1'b0;
    @(negedge clock);
    n_checks++; if (rdy[0] !== 1'b1 || rv[0] !== 1'b1 || er[0] !== 1'b0) begin n_errors++;
      $display("FAIL b2b_second_accept: got rdy=%b rv=%b e=%b expected 1 1 0",
               rdy[0], rv[0], er[0]); end
    @(posedge clock); #1 req_s[0] = 1'b0;
    @(negedge clock);
    n_checks++; if (rv[0] !== 1'b1 || rd[0] !== 32'h5A5AA5A5) begin n_errors++;
      $display("FAIL read_after_write: got rv=%b d=%h expected 1 5a5aa5a5", rv[0], rd[0]); end
    mem_a[20] = 32'h5A5AA5A5;
  endtask

  task automatic test_contention();
    bit acc; logic grv, ger; logic [31:0] grd;
    logic [31:0] want [2];
    int prev;
    want[0] = mem_a[16]; want[1] = mem_a[20];
    // A p1 accept leaves p0 as the next tie winner.
    do_access(1, 1'b0, 10'd64, 4'h0, 32'h0, acc, grv, grd, ger);
    n_checks++; if (grv !== 1'b1 || grd !== mem_a[16]) begin n_errors++;
      $display("FAIL p1_read: got rv=%b d=%h expected 1 %h", grv, grd, mem_a[16]); end
    @(posedge clock); #1;
    req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 10'd64;
    req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 10'd80;
    prev = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      n_checks++;
      if (rdy[0] !== (c % 2 == 0) || rdy[1] !== (c % 2 == 1)) begin n_errors++;
        $display("FAIL contention_grant%0d: got rdy1=%b rdy0=%b expected port %0d",
                 c, rdy[1], rdy[0], c % 2); end
      if (prev >= 0) begin
        n_checks++;
        if (rv[prev] !== 1'b1 || rv[1-prev] !== 1'b0 || rd[prev] !== want[prev]) begin
          n_errors++;
          $display("FAIL contention_resp%0d: got rv=%b%b d=%h expected port %0d d=%h",
                   c, rv[1], rv[0], rd[prev], prev, want[prev]); end
      end
      prev = c % 2;
      @(posedge clock); #1;
    end
    req_s[0] = 1'b0; req_s[1] = 1'b0;
    @(negedge clock);
    n_checks++; if (rv[1] !== 1'b1 || rd[1] !== want[1]) begin n_errors++;
      $display("FAIL contention_last_resp: got rv=%b d=%h expected 1 %h", rv[1], rd[1],
               want[1]); end
  endtask

  task automatic test_out_of_range();
    bit acc; logic grv, ger; logic [31:0] grd;
    do_access(3, 1'b1, 10'h014, 4'hF, 32'hDEADBEEF, acc, grv, grd, ger);
    do_access(3, 1'b0, 10'h014, 4'h0, 32'h0, acc, grv, grd, ger);
    n_checks++; if (grv !== 1'b1 || grd !== 32'hDEADBEEF || ger !== 1'b0) begin n_errors++;
      $display("FAIL oor_setup_read: got rv=%b d=%h e=%b expected 1 deadbeef 0",
               grv, grd, ger); end
    do_access(3, 1'b1, 10'h320, 4'hF, 32'h12345678, acc, grv, grd, ger);
    n_checks++; if (!acc || grv !== 1'b1 || ger !== 1'b1) begin n_errors++;
      $display("FAIL oor_write: got acc=%b rv=%b e=%b expected 1 1 1", acc, grv, ger); end
    do_access(3, 1'b0, 10'h320, 4'h0, 32'h0, acc, grv, grd, ger);
    n_checks++; if (grv !== 1'b1 || grd !== 32'h0 || ger !== 1'b1) begin n_errors++;
      $display("FAIL oor_read: got rv=%b d=%h e=%b expected 1 0 1", grv, grd, ger); end
    do_access(3, 1'b0, 10'd796, 4'h0, 32'h0, acc, grv, grd, ger);
    n_checks++; if (grv !== 1'b1 || grd !== 32'h0 || ger !== 1'b0) begin n_errors++;
      $display("FAIL last_word_read: got rv=%b d=%h e=%b expected 1 0 0", grv, grd, ger); end
    do_access(3, 1'b0, 10'h014, 4'h0, 32'h0, acc, grv, grd, ger);
    n_checks++; if (grd !== 32'hDEADBEEF || ger !== 1'b0) begin n_errors++;
      $display("FAIL oor_no_alias: got d=%h e=%b expected deadbeef 0", grd, ger); end
  endtask

  task automatic test_clear_request();
    bit acc; logic grv, ger; logic [31:0] grd;
    int busy_cnt, bad_rdy;
    for (int i = 0; i < 4; i++) begin
      do_access(0, 1'b1, 10'(i * 4), 4'hF, 32'hFFFFFFFF, acc, grv, grd, ger);
    end
    do_access(0, 1'b0, 10'd8, 4'h0, 32'h0, acc, grv, grd, ger);
    n_checks++; if (grd !== 32'hFFFFFFFF) begin n_errors++;
      $display("FAIL fill_read: got %h expected ffffffff", grd); end
    @(posedge clock); #1;
    req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 10'd8; clr_a = 1'b1;
    @(negedge clock);
    n_checks++; if (rdy[0] !== 1'b0) begin n_errors++;
      $display("FAIL clear_priority: got ready %b expected 0", rdy[0]); end
    @(posedge clock); #1 clr_a = 1'b0;
    busy_cnt = 0; bad_rdy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (busy_a !== 1'b1) break;
      busy_cnt++;
      if (rdy[0] !== 1'b0) bad_rdy++;
    end
    n_checks++; if (busy_cnt != 256 || bad_rdy != 0) begin n_errors++;
      $display("FAIL clear_req_len: got %0d busy %0d ready expected 256 0",
               busy_cnt, bad_rdy); end
    n_checks++; if (rdy[0] !== 1'b1) begin n_errors++;
      $display("FAIL held_req_accept: got %b expected 1", rdy[0]); end
    @(posedge clock); #1 req_s[0] = 1'b0;
    @(negedge clock);
    n_checks++; if (rv[0] !== 1'b1 || rd[0] !== 32'h0) begin n_errors++;
      $display("FAIL cleared_read: got rv=%b d=%h expected 1 0", rv[0], rd[0]); end
    for (int i = 0; i < 256; i++) mem_a[i] = '0;
  endtask

  task automatic test_reset_mid_clear();
    bit acc; logic grv, ger; logic [31:0] grd;
    int busy_cnt, bad;
    do_access(0, 1'b1, 10'd120, 4'hF, 32'hCAFEF00D, acc, grv, grd, ger);
    do_access(0, 1'b0, 10'd120, 4'h0, 32'h0, acc, grv, grd, ger);
    n_checks++; if (grd !== 32'hCAFEF00D) begin n_errors++;
      $display("FAIL pre_reset_read: got %h expected cafef00d", grd); end
    @(posedge clock); #1;
    clr_a = 1'b1; req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 10'd120;
    @(posedge clock); #1 clr_a = 1'b0;
    repeat (100) @(posedge clock);
    #1 reset = 1'b0;
    req_s[1] = 1'b0;
    @(negedge clock);
    n_checks++; if (busy_a !== 1'b1 || rv[1] !== 1'b0 || rdy[1] !== 1'b0) begin n_errors++;
      $display("FAIL in_reset_ctrl: got busy=%b rv=%b rdy=%b expected 1 0 0",
               busy_a, rv[1], rdy[1]); end
    n_checks++; if (rd[0] !== 32'h0 || rd[1] !== 32'h0) begin n_errors++;
      $display("FAIL in_reset_rdata: got %h %h expected 0 0", rd[0], rd[1]); end
    @(posedge clock); #1 reset = 1'b1;
    busy_cnt = 0; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (busy_a !== 1'b1) break;
      busy_cnt++;
      if (rv[0] !== 1'b0 || rv[1] !== 1'b0) bad++;
    end
    n_checks++; if (busy_cnt != 256) begin n_errors++;
      $display("FAIL restart_clear_len: got %0d expected 256", busy_cnt); end
    repeat (2) @(negedge clock) if (rv[1] !== 1'b0) bad++;
    n_checks++; if (bad != 0) begin n_errors++;
      $display("FAIL lost_rvalid: got %0d stray responses expected 0", bad); end
    for (int i = 0; i < 256; i++) mem_a[i] = '0;
  endtask

  task automatic test_random();
    bit act [2];
    bit exp_rv [2];
    logic [31:0] hold [2];
    bit last;
    int gp, w;
    last = 1'b1;
    for (int p = 0; p < 2; p++) begin act[p] = 0; exp_rv[p] = 0; hold[p] = '0; end
    @(posedge clock); #1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 2) != 0) begin
          act[p] = 1;
          req_s[p] = 1'b1;
          we_s[p] = 1'($urandom_range(0, 1));
          addr_s[p] = 10'($urandom_range(0, 255));
          be_s[p] = 4'($urandom_range(0, 15));
          wd_s[p] = $urandom;
        end
      end
      @(negedge clock);
      if (act[0] && act[1]) gp = last ? 0 : 1;
      else if (act[0]) gp = 0;
      else if (act[1]) gp = 1;
      else gp = -1;
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (rdy[p] !== (gp == p) || rv[p] !== exp_rv[p] || (exp_rv[p] && er[p] !== 1'b0)
            || rd[p] !== hold[p]) begin
          n_errors++;
          $display("FAIL rand_c%0d_p%0d: got rdy=%b rv=%b e=%b d=%h expected rdy=%b rv=%b e=0 d=%h",
                   cyc, p, rdy[p], rv[p], er[p], rd[p], gp == p, exp_rv[p], hold[p]);
        end
      end
      exp_rv[0] = 0; exp_rv[1] = 0;
      if (gp >= 0) begin
        w = int'(addr_s[gp][9:2]);
        if (we_s[gp]) begin
          for (int b = 0; b < 4; b++) if (be_s[gp][b]) mem_a[w][8*b +: 8] = wd_s[gp][8*b +: 8];
        end else begin
          hold[gp] = mem_a[w];
        end
        exp_rv[gp] = 1;
        last = (gp == 1);
        act[gp] = 0;
      end
      @(posedge clock); #1;
      for (int p = 0; p < 2; p++) if (!act[p]) req_s[p] = 1'b0;
    end
    req_s[0] = 1'b0; req_s[1] = 1'b0;
    repeat (3) @(posedge clock);
  endtask

  initial begin
    clr_a = 1'b0; clr_b = 1'b0;
    for (int p = 0; p < 4; p++) begin
      req_s[p] = 1'b0; we_s[p] = 1'b0; addr_s[p] = '0; be_s[p] = '0; wd_s[p] = '0;
    end
    test_reset();
    test_byte_lanes();
    test_back_to_back();
    test_contention();
    test_out_of_range();
    test_clear_request();
    test_reset_mid_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
